// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Opcode/funct codes, FSM state encoding and control-field codes
//            shared by the multicycle MIPS control path.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_j     = 6'h02;

  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;
  localparam logic [5:0] c_fn_or  = 6'h25;
  localparam logic [5:0] c_fn_slt = 6'h2A;

  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_sub = 3'b110;
  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_slt = 3'b111;

  localparam logic [1:0] c_srcb_regb  = 2'b00;
  localparam logic [1:0] c_srcb_four  = 2'b01;
  localparam logic [1:0] c_srcb_imm   = 2'b10;
  localparam logic [1:0] c_srcb_immsh = 2'b11;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_mc_control_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_control_if
// Brief    : Control-path bundle between the multicycle FSM (master) and the
//            datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mips_mc_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] pc_src;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_decoder
// Brief    : Maps the FSM's coarse ALU request plus funct to an ALU control code.
// Revision : 1.0 - initial release
// ============================================================================
module mips_alu_decoder
  import mips_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_bad_funct
);

  always_comb begin
    o_alu_ctrl  = c_alu_add;
    o_bad_funct = 1'b0;
    case (i_alu_op)
      ALU_OP_SUB: o_alu_ctrl = c_alu_sub;
      ALU_OP_FUNCT: begin
        case (i_funct)
          c_fn_add: o_alu_ctrl = c_alu_add;
          c_fn_sub: o_alu_ctrl = c_alu_sub;
          c_fn_and: o_alu_ctrl = c_alu_and;
          c_fn_or:  o_alu_ctrl = c_alu_or;
          c_fn_slt: o_alu_ctrl = c_alu_slt;
          default:  o_bad_funct = 1'b1;
        endcase
      end
      default: o_alu_ctrl = c_alu_add;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_control
// Brief    : Multicycle MIPS control FSM driving ALU muxes, memory and regfile.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_control
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  mips_mc_control_if.master  bus
);

  state_t     r_state;
  state_t     w_next;
  alu_op_t    w_alu_op;
  logic [2:0] w_alu_ctrl;
  logic       w_bad_funct;
  logic       w_pc_en;
  logic       w_ir_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Kept outside the main decode so bad_funct does not loop back into it.
  assign w_alu_op = (r_state == S_EXEC)   ? ALU_OP_FUNCT :
                    (r_state == S_BRANCH) ? ALU_OP_SUB   : ALU_OP_ADD;

  mips_alu_decoder u_alu_dec (
    .i_alu_op    (w_alu_op),
    .i_funct     (bus.funct),
    .o_alu_ctrl  (w_alu_ctrl),
    .o_bad_funct (w_bad_funct)
  );

  always_comb begin
    w_next         = S_FETCH;
    w_pc_en        = 1'b0;
    w_ir_write     = 1'b0;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_reg_write    = 1'b0;
    w_illegal      = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = c_srcb_regb;
    bus.pc_src     = c_pcsrc_alu;
    case (r_state)
      S_FETCH: begin
        w_mem_read    = 1'b1;
        bus.alu_src_b = c_srcb_four;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_en    = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = c_srcb_immsh;
        case (bus.op)
          c_op_lw, c_op_sw: w_next = S_MEMADR;
          c_op_rtype:       w_next = S_EXEC;
          c_op_beq:         w_next = S_BRANCH;
          c_op_addi:        w_next = S_ADDIEX;
          c_op_j:           w_next = S_JUMP;
          default:          w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = c_srcb_imm;
        w_next        = (bus.op == c_op_lw) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        bus.i_or_d = 1'b1;
        w_next     = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_reg_write    = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        bus.i_or_d  = 1'b1;
        w_next      = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        if (w_bad_funct) w_illegal = 1'b1;
        else             w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        bus.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.pc_src    = c_pcsrc_aluout;
        w_pc_en       = bus.zero;
      end
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = c_srcb_imm;
        w_next        = S_ADDIWB;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        bus.pc_src = c_pcsrc_jump;
        w_pc_en    = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are forced low for as long as reset is held, not just at the edge.
  assign bus.pc_en     = w_pc_en     & reset_n;
  assign bus.ir_write  = w_ir_write  & reset_n;
  assign bus.mem_read  = w_mem_read  & reset_n;
  assign bus.mem_write = w_mem_write & reset_n;
  assign bus.reg_write = w_reg_write & reset_n;
  assign bus.illegal   = w_illegal   & reset_n;
  assign bus.alu_ctrl  = w_alu_ctrl;
  assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_control
// Brief    : Self-checking bench for mips_mc_control against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_control;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_err;

  mips_mc_control_if bus ();

  mips_mc_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: each instruction is a timeline of f fetch-wait cycles, a fetch
  // cycle, then a fixed per-class tail; data accesses start at cycle f+3.
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                           input int f, input int d, input int zmode);
    int   base, len, ds;
    bit   is_lw, is_sw, is_beq, is_j, is_r, wr, ill, rdst, m2r, z, dacc;
    logic [2:0] ealu;
    is_lw = 0; is_sw = 0; is_beq = 0; is_j = 0; is_r = 0;
    wr = 0; ill = 0; rdst = 0; m2r = 0; ealu = 3'b010; base = 2;
    case (iop)
      6'h23: begin is_lw = 1; base = 5; wr = 1; m2r = 1; end
      6'h2B: begin is_sw = 1; base = 4; end
      6'h04: begin is_beq = 1; base = 3; end
      6'h08: begin base = 4; wr = 1; end
      6'h02: begin is_j = 1; base = 3; end
      6'h00: begin
        is_r = 1;
        case (ifn)
          6'h20: ealu = 3'b010;
          6'h22: ealu = 3'b110;
          6'h24: ealu = 3'b000;
          6'h25: ealu = 3'b001;
          6'h2A: ealu = 3'b111;
          default: ill = 1;
        endcase
        if (ill) base = 3;
        else begin base = 4; wr = 1; rdst = 1; end
      end
      default: begin ill = 1; base = 2; end
    endcase
    len = base + f + ((is_lw || is_sw) ? d : 0);
    ds  = f + 3;
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      bus.op    = iop;
      bus.funct = ifn;
      dacc      = (is_lw || is_sw) && c >= ds && c <= ds + d;
      if (c < f)                           bus.mem_ready = 1'b0;
      else if (c == f)                     bus.mem_ready = 1'b1;
      else if ((is_lw || is_sw) && c >= ds) bus.mem_ready = (c >= ds + d);
      else                                 bus.mem_ready = 1'($urandom % 2);
      z = (zmode < 0) ? 1'($urandom % 2) : 1'(zmode);
      bus.zero = z;
      #3;
      if (c == 0)     chk("state_fetch",  bus.state, 4'd0);
      if (c == f + 1) chk("state_decode", bus.state, 4'd1);
      chk("mem_read",  4'(bus.mem_read),  4'((c <= f) || (is_lw && dacc)));
      chk("mem_write", 4'(bus.mem_write), 4'(is_sw && dacc));
      chk("ir_write",  4'(bus.ir_write),  4'(c == f));
      chk("pc_en",     4'(bus.pc_en),
          4'((c == f) || (c == len - 1 && (is_j || (is_beq && z)))));
      chk("reg_write", 4'(bus.reg_write), 4'(wr && c == len - 1));
      chk("illegal",   4'(bus.illegal),   4'(ill && c == len - 1));
      chk("excl", 4'((bus.mem_read & bus.mem_write) | (bus.reg_write & bus.pc_en)), 4'd0);
      if (c <= f) begin
        chk("fetch_src_a", 4'(bus.alu_src_a), 4'd0);
        chk("fetch_src_b", 4'(bus.alu_src_b), 4'd1);
        chk("fetch_alu",   4'(bus.alu_ctrl),  4'd2);
        chk("fetch_iord",  4'(bus.i_or_d),    4'd0);
      end
      if (dacc) chk("data_iord", 4'(bus.i_or_d), 4'd1);
      if (wr && c == len - 1) begin
        chk("reg_dst",    4'(bus.reg_dst),    4'(rdst));
        chk("mem_to_reg", 4'(bus.mem_to_reg), 4'(m2r));
      end
      if (is_r && !ill && c == f + 2) begin
        chk("exec_alu",   4'(bus.alu_ctrl),  4'(ealu));
        chk("exec_src_a", 4'(bus.alu_src_a), 4'd1);
        chk("exec_src_b", 4'(bus.alu_src_b), 4'd0);
      end
      if (is_beq && c == len - 1) begin
        chk("beq_pc_src", 4'(bus.pc_src),   4'd1);
        chk("beq_alu",    4'(bus.alu_ctrl), 4'd6);
      end
      if (is_j && c == len - 1) chk("j_pc_src", 4'(bus.pc_src), 4'd2);
    end
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] fns [5];
    logic [5:0] rop, rfn;
    n_checks = 0;
    n_err    = 0;
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    reset_n       = 1'b0;
    bus.op        = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state",     bus.state,           4'd0);
    chk("rst_mem_read",  4'(bus.mem_read),    4'd0);
    chk("rst_pc_en",     4'(bus.pc_en),       4'd0);
    chk("rst_ir_write",  4'(bus.ir_write),    4'd0);
    chk("rst_reg_write", 4'(bus.reg_write),   4'd0);
    chk("rst_illegal",   4'(bus.illegal),     4'd0);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_state",    bus.state,          4'd0);
    chk("rel_mem_read", 4'(bus.mem_read),   4'd1);
    chk("rel_ir_write", 4'(bus.ir_write),   4'd0);

    run_instr(6'h00, 6'h20, 0, 0, -1);   // add
    run_instr(6'h23, 6'h00, 0, 2, -1);   // lw, two data wait cycles
    run_instr(6'h04, 6'h00, 0, 0, 1);    // beq taken
    run_instr(6'h04, 6'h00, 0, 0, 0);    // beq not taken
    run_instr(6'h3F, 6'h00, 0, 0, -1);   // illegal op
    run_instr(6'h00, 6'h3F, 0, 0, -1);   // illegal funct
    run_instr(6'h02, 6'h00, 3, 0, -1);   // j, fetch stalled
    run_instr(6'h2B, 6'h00, 1, 3, -1);   // sw with waits
    run_instr(6'h08, 6'h00, 2, 0, -1);   // addi

    for (int i = 0; i < 80; i++) begin
      rop = ops[$urandom_range(0, 6)];
      if ($urandom % 5 == 0) rop = 6'($urandom);
      rfn = fns[$urandom_range(0, 4)];
      if ($urandom % 4 == 0) rfn = 6'($urandom);
      run_instr(rop, rfn, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    // Reset in the middle of a stalled store.
    @(posedge clk); #1;
    bus.op = 6'h2B; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    #1;
    chk("memwr_state", bus.state,          4'd5);
    chk("memwr_write", 4'(bus.mem_write),  4'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_write", 4'(bus.mem_write), 4'd0);
    chk("midrst_state", bus.state,         4'd0);
    chk("midrst_read",  4'(bus.mem_read),  4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("postrst_state", bus.state,         4'd0);
    chk("postrst_read",  4'(bus.mem_read),  4'd1);
    chk("postrst_irw",   4'(bus.ir_write),  4'd0);
    @(posedge clk); #1;
    chk("hold_state", bus.state,        4'd0);
    chk("hold_irw",   4'(bus.ir_write), 4'd0);
    bus.mem_ready = 1'b1;
    #1;
    chk("ready_irw",   4'(bus.ir_write), 4'd1);
    chk("ready_pc_en", 4'(bus.pc_en),    4'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
